// File: rtl/ag_pattern_pkg.sv
// ag_pattern_pkg: shared types and helper functions for the ag_pattern_gen test-pattern generator.
package ag_pattern_pkg;

  // Pattern selection latched at start; codes above LFSR fall back to CHECKER.
  typedef enum logic [2:0] {
    CHECKER = 3'd0,
    WALK1   = 3'd1,
    WALK0   = 3'd2,
    INCR    = 3'd3,
    LFSR    = 3'd4
  } pattern_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [2:0] LAST_MODE = 3'd4;

  // Alternating-bit word: phase 0 gives 'hAA.., phase 1 gives 'h55.., masked to width bits.
  function automatic logic [31:0] checker_word(input int width, input logic phase);
    logic [31:0] mask;
    mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (phase ? 32'h5555_5555 : 32'hAAAA_AAAA) & mask;
  endfunction

  // Galois right-shift feedback taps for each legal data width.
  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      8:       return 32'h0000_00B8;
      16:      return 32'h0000_B400;
      default: return 32'h8020_0003;
    endcase
  endfunction

endpackage

// File: rtl/ag_lfsr.sv
// ag_lfsr: Galois right-shift LFSR with synchronous load taking priority over step.
module ag_lfsr #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(32'hB8)
) (
  input  logic             clk_i,
  input  logic             arstn_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic             step_i,
  output logic [WIDTH-1:0] state_o
);

  // Load a block seed, otherwise advance one step per accepted word.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_o <= WIDTH'(1);
    end else if (load_i) begin
      state_o <= seed_i;
    end else if (step_i) begin
      state_o <= (state_o >> 1) ^ (state_o[0] ? TAPS : '0);
    end
  end

endmodule

// File: rtl/ag_pattern_gen.sv
// ag_pattern_gen: writes NUM_BLOCKS blocks of LENGTH pattern words, then replays each block
// as expected data and counts read-back mismatches.
// Optional first-error capture registers: define AG_PATTERN_GEN_ERR_LOG_EN.
module ag_pattern_gen
  import ag_pattern_pkg::*;
#(
  parameter int          WIDTH      = 8,
  parameter int          LENGTH     = 512,
  parameter int          NUM_BLOCKS = 2,
  parameter logic [31:0] LFSR_SEED  = 32'h1,
  parameter int          ERR_CNT_W  = 16
) (
  input  logic                          clk_i,
  input  logic                          arstn_i,
  input  logic                          start_i,
  input  logic [2:0]                    mode_i,
  input  logic                          ready_i,
  output logic                          valid_o,
  output logic [WIDTH-1:0]              data_o,
  output logic                          wr_enbl_o,
  output logic                          busy_o,
  output logic                          finished_o,
  input  logic [WIDTH-1:0]              rd_data_i,
  input  logic                          rd_valid_i,
  output logic [ERR_CNT_W-1:0]          err_cnt_o,
  output logic                          err_o,
  output logic [$clog2(LENGTH)-1:0]     first_err_idx_o,
  output logic [$clog2(NUM_BLOCKS):0]   first_err_blk_o,
  output logic [WIDTH-1:0]              first_err_exp_o,
  output logic [WIDTH-1:0]              first_err_act_o
);

  localparam int               IW        = $clog2(LENGTH);
  localparam int               BW        = $clog2(NUM_BLOCKS) + 1;
  localparam logic [WIDTH-1:0] TAPS      = WIDTH'(lfsr_taps(WIDTH));
  localparam logic [WIDTH-1:0] SEED_BASE = WIDTH'(LFSR_SEED);

  state_e               state, state_d;
  pattern_mode_e        mode_q;
  logic [BW-1:0]        blk;
  logic [IW-1:0]        idx;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic                 err_flag;
  logic                 active, xfer, last_word, last_blk, start_ok, rd_err;
  logic [WIDTH-1:0]     pattern, lfsr_state, lfsr_seed, seed_raw;
  logic                 lfsr_load;
  logic [BW-1:0]        seed_blk;
  int unsigned          walk_pos;

  assign active    = (state == WRITE) || (state == READ);
  assign xfer      = active && ready_i;
  assign last_word = (idx == IW'(LENGTH - 1));
  assign last_blk  = (blk == BW'(NUM_BLOCKS - 1));
  assign start_ok  = (state == IDLE) && start_i;
  assign rd_err    = (state == READ) && xfer && (!rd_valid_i || (rd_data_i != pattern));

  assign data_o    = active ? pattern : '0;
  assign err_cnt_o = err_cnt;
  assign err_o     = err_flag;

  // Phase state register; reset aborts any sequence in flight.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next phase and handshake/status outputs, all derived from the current phase.
  always_comb begin
    state_d    = state;
    valid_o    = 1'b0;
    wr_enbl_o  = 1'b0;
    busy_o     = 1'b0;
    finished_o = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) state_d = WRITE;
      end
      WRITE: begin
        valid_o   = 1'b1;
        wr_enbl_o = 1'b1;
        busy_o    = 1'b1;
        if (xfer && last_word) state_d = READ;
      end
      READ: begin
        valid_o = 1'b1;
        busy_o  = 1'b1;
        if (xfer && last_word) state_d = last_blk ? DONE : WRITE;
      end
      DONE: begin
        finished_o = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Mode latch plus block/word position, which only moves on an accepted word.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      mode_q <= CHECKER;
      blk    <= '0;
      idx    <= '0;
    end else if (start_ok) begin
      mode_q <= (mode_i > LAST_MODE) ? CHECKER : pattern_mode_e'(mode_i);
      blk    <= '0;
      idx    <= '0;
    end else if (xfer) begin
      if (last_word) begin
        idx <= '0;
        if (state == READ) blk <= blk + 1'b1;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  // Current word of the selected pattern as a pure function of block and word position.
  always_comb begin
    walk_pos = (32'(idx) + 32'(blk)) % WIDTH;
    case (mode_q)
      WALK1:   pattern = WIDTH'(1) << walk_pos;
      WALK0:   pattern = ~(WIDTH'(1) << walk_pos);
      INCR:    pattern = WIDTH'(32'(blk) * 32'(LENGTH) + 32'(idx));
      LFSR:    pattern = lfsr_state;
      default: pattern = WIDTH'(checker_word(WIDTH, idx[0] ^ blk[0]));
    endcase
  end

  // Reseed the LFSR whenever a block phase begins so READ replays exactly what WRITE sent.
  always_comb begin
    seed_blk  = '0;
    lfsr_load = 1'b0;
    if (start_ok) begin
      lfsr_load = 1'b1;
    end else if (xfer && last_word) begin
      if (state == WRITE) begin
        seed_blk  = blk;
        lfsr_load = 1'b1;
      end else if (!last_blk) begin
        seed_blk  = blk + 1'b1;
        lfsr_load = 1'b1;
      end
    end
    seed_raw  = SEED_BASE ^ WIDTH'(seed_blk);
    lfsr_seed = (seed_raw == '0) ? WIDTH'(1) : seed_raw;
  end

  ag_lfsr #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_lfsr (
    .clk_i   (clk_i),
    .arstn_i (arstn_i),
    .load_i  (lfsr_load),
    .seed_i  (lfsr_seed),
    .step_i  (xfer),
    .state_o (lfsr_state)
  );

  // Saturating mismatch counter and sticky error flag, cleared when a new sequence starts.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      err_cnt  <= '0;
      err_flag <= 1'b0;
    end else if (start_ok) begin
      err_cnt  <= '0;
      err_flag <= 1'b0;
    end else if (rd_err) begin
      if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      err_flag <= 1'b1;
    end
  end

`ifdef AG_PATTERN_GEN_ERR_LOG_EN
  logic [IW-1:0]    fe_idx;
  logic [BW-1:0]    fe_blk;
  logic [WIDTH-1:0] fe_exp, fe_act;

  // Snapshot position and data of the first mismatch after start; later errors leave it alone.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      fe_idx <= '0;
      fe_blk <= '0;
      fe_exp <= '0;
      fe_act <= '0;
    end else if (start_ok) begin
      fe_idx <= '0;
      fe_blk <= '0;
      fe_exp <= '0;
      fe_act <= '0;
    end else if (rd_err && !err_flag) begin
      fe_idx <= idx;
      fe_blk <= blk;
      fe_exp <= pattern;
      fe_act <= rd_data_i;
    end
  end

  assign first_err_idx_o = fe_idx;
  assign first_err_blk_o = fe_blk;
  assign first_err_exp_o = fe_exp;
  assign first_err_act_o = fe_act;
`else
  assign first_err_idx_o = '0;
  assign first_err_blk_o = '0;
  assign first_err_exp_o = '0;
  assign first_err_act_o = '0;
`endif

endmodule

// File: doc/ag_pattern_gen.md
Name: ag_pattern_gen

Overview:
- Multi-mode test-pattern generator for eMMC data-path verification.
- Writes NUM_BLOCKS blocks of LENGTH words, then re-emits each block's expected data while checking read-back data against it.
- Sits between the test sequencer (start/mode) and the bus-side write/read adapter, which consumes words with a valid/ready handshake.
- Successor to the fixed checkerboard generator: adds selectable patterns, parametrised block count, backpressure and built-in compare with error counting.

Parameters:
- WIDTH, 8: data word width; legal values 8, 16, 32.
- LENGTH, 512: words per block; must be >= 2.
- NUM_BLOCKS, 2: number of write/read block pairs; must be >= 1.
- LFSR_SEED, 'h1: LFSR base seed; must be non-zero in the low WIDTH bits.
- ERR_CNT_W, 16: width of the error counter.

Ports:
- clk_i  in  1  clock.
- arstn_i  in  1  asynchronous active-low reset.
- start_i  in  1  start-sequence pulse; sampled only in IDLE.
- mode_i  in  3  pattern select; latched when start is accepted.
- ready_i  in  1  consumer accepts data_o this cycle.
- valid_o  out  1  data_o is valid.
- data_o  out  WIDTH  write data (WRITE phase) or expected data (READ phase).
- wr_enbl_o  out  1  1 = WRITE phase, 0 = READ phase.
- busy_o  out  1  high from start acceptance until finished_o.
- finished_o  out  1  one-cycle completion pulse.
- rd_data_i  in  WIDTH  read-back data, aligned to the READ handshake.
- rd_valid_i  in  1  rd_data_i is valid.
- err_cnt_o  out  ERR_CNT_W  saturating mismatch count.
- err_o  out  1  sticky: at least one error since start.
- first_err_idx_o  out  clog2(LENGTH)  index of the first error (see optional feature).
- first_err_blk_o  out  clog2(NUM_BLOCKS)+1  block of the first error.
- first_err_exp_o  out  WIDTH  expected data at the first error.
- first_err_act_o  out  WIDTH  actual data at the first error.

Behaviour:
- Reset (async, arstn_i low), all outputs 0:
  - state = IDLE; valid_o = 0; wr_enbl_o = 0; busy_o = 0; finished_o = 0.
  - err_cnt_o = 0; err_o = 0; first_err_* = 0.
  - Reset mid-sequence aborts immediately; no finished_o is produced.
- FSM states are IDLE, WRITE, READ, DONE.
- IDLE:
  - start_i = 1 -> latch mode_i, set block b = 0 and word i = 0, clear err_cnt_o, err_o and first_err_*.
  - Next cycle enters WRITE with valid_o = 1, wr_enbl_o = 1, busy_o = 1.
- Handshake:
  - A transfer occurs when valid_o & ready_i.
  - i advances only on a transfer.
  - data_o is held stable while ready_i = 0.
  - valid_o stays 1 throughout WRITE and READ; there are no bubbles.
- WRITE:
  - Transfer with i = LENGTH-1 -> i = 0, next state READ (wr_enbl_o = 0).
  - The pattern generator is restored to block b's start value.
- READ:
  - data_o is the same sequence as WRITE for block b.
  - On each transfer, the word is an error if rd_valid_i = 0 or rd_data_i != data_o.
  - On error: err_cnt_o increments, saturating at all-ones, and err_o is set.
  - Transfer with i = LENGTH-1:
    - If b < NUM_BLOCKS-1 -> b++, next state WRITE.
    - Otherwise -> DONE.
  - rd_valid_i outside a READ transfer is ignored.
- DONE:
  - One cycle: finished_o = 1, valid_o = 0, busy_o = 0.
  - Then IDLE; err_cnt_o and err_o hold until the next start.
  - start_i during DONE is ignored.
- start_i outside IDLE is ignored; mode_i changes mid-sequence have no effect.
- Patterns, for word i of block b:
  - 0 CHECKER: i even -> 'hAA.., i odd -> 'h55..; inverted when b is odd.
  - 1 WALK1: 1 << ((i+b) mod WIDTH).
  - 2 WALK0: bitwise NOT of WALK1.
  - 3 INCR: (b*LENGTH + i) mod 2^WIDTH, wrapping silently.
  - 4 LFSR: Galois LFSR, right-shift, taps from the package. Loaded with LFSR_SEED ^ b at block start, or 1 if that value is 0. data_o = LFSR state; the LFSR steps on each transfer.
  - 5-7: treated as CHECKER.

Optional Feature:
- Macro: AG_PATTERN_GEN_ERR_LOG_EN.
- Defined: on the first error since start, capture i, b, expected data and actual data into first_err_*. These hold until the next start.
- Undefined: first_err_* are tied to 0 and no capture registers are built. err_cnt_o and err_o are unaffected either way.

Decomposition:
- Package ag_pattern_pkg:
  - pattern_mode_e enum (CHECKER, WALK1, WALK0, INCR, LFSR).
  - state_e enum.
  - Function checker_word(WIDTH, phase).
  - Function lfsr_taps(WIDTH): 8 -> 'hB8, 16 -> 'hB400, 32 -> 'h80200003.
- Sub-module ag_lfsr:
  - Parameters WIDTH and taps.
  - Inputs load_i, seed_i, step_i; output state_o.
  - Synchronous load has priority over step.
  - Instantiated once.

Test Plan:
1. CHECKER, WIDTH=8, LENGTH=4, NUM_BLOCKS=2, ready_i=1, loopback (rd_data_i = data_o, rd_valid_i = 1):
   - Expected data_o: AA,55,AA,55 (W) ×2, then 55,AA,55,AA (W) ×2.
   - finished_o pulses 17 cycles after start; err_cnt_o = 0.
2. WALK1, WIDTH=8, LENGTH=10: block 0 data_o = 01,02,04,…,80,01,02; block 1 starts at 02.
3. Backpressure: ready_i toggled randomly in INCR mode -> data_o is stable while stalled, no word is skipped or repeated, the block 1 first word = LENGTH mod 256.
4. Error injection: corrupt rd_data_i on READ word 3 of block 1 and drop rd_valid_i on word 5:
   - err_cnt_o = 2, err_o = 1.
   - With the macro defined: first_err_idx_o = 3, first_err_blk_o = 1, with the corresponding expected and actual values.
5. LFSR, WIDTH=16, seed 'h1: the READ sequence equals the WRITE sequence for each block; block 1 starts from 'h0001 ^ 1 -> 'h0001 (the zero substitute).
6. arstn_i asserted in READ of block 0 -> all outputs 0 immediately, no finished_o. A new start with ERR_CNT_W=2 and 5 errors -> err_cnt_o saturates at 3.
